cam_dvp_pattern_tx: RTL and testbench

Synthesizable OV7670-style DVP transmitter (camera emulator). Generates vsync/href/8-bit byte stream in RGB444 (xR GB) format with OV7670 frame timing and internal test patterns. Drives the camera capture path's pixel inputs in place of the sensor, for board bring-up and simulation of the pp/gaussian/sobel/mem/display chain without a camera. One byte is emitted per clock-enable.

---
 rtl/cam_dvp_pattern_tx_if.sv | 24 ++
 rtl/cam_dvp_pattern_tx.sv | 194 +++++++++++++++++++
 tb/tb_cam_dvp_pattern_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cam_dvp_pattern_tx_if.sv
// DVP pattern transmitter bundle: control inputs and the emulated sensor outputs.
// The master side is the transmitter. The slave side is whoever drives the controls and consumes the byte stream.
interface cam_dvp_pattern_tx_if;
  logic        i_ce;
  logic        i_enable;
  logic [1:0]  i_pattern;
  logic [11:0] i_solid_color;
  logic        o_vsync;
  logic        o_href;
  logic [7:0]  o_data;
  logic        o_sof;
  logic        o_busy;
  logic [15:0] o_frame_cnt;

  modport master (
    input  i_ce, i_enable, i_pattern, i_solid_color,
    output o_vsync, o_href, o_data, o_sof, o_busy, o_frame_cnt
  );

  modport slave (
    output i_ce, i_enable, i_pattern, i_solid_color,
    input  o_vsync, o_href, o_data, o_sof, o_busy, o_frame_cnt
  );
endinterface

// File: rtl/cam_dvp_pattern_tx.sv
// OV7670-style DVP camera emulator: vsync/href/RGB444 byte stream with internal test patterns.
// Outputs are registered from next-state values, so every output changes on the same edge as the state.
module cam_dvp_pattern_tx #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cam_dvp_pattern_tx_if.master dvp
);

  localparam int unsigned LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned BXW      = $clog2(LINE_LEN);
  localparam int unsigned BAR_W    = H_ACTIVE / 8;
  localparam int unsigned BCW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [BXW-1:0] BX_LAST  = BXW'(LINE_LEN - 1);
  localparam logic [BXW-1:0] HREF_END = BXW'(2 * H_ACTIVE);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(BAR_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  state_e          state_q, state_d;
  logic [BXW-1:0]  bx_q, bx_d;
  logic [15:0]     ln_q, ln_d;
  logic [15:0]     ln_last;
  logic            start;

  logic [2:0]      bar_q, bar_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [1:0]      pat_q, pat_d;
  logic [11:0]     solid_q, solid_d;

  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      data_q, data_d;
  logic            sof_q, sof_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic [11:0]     col;
  logic [3:0]      ramp_v;
  logic            chk_x;

  // Line count of the current state, minus one.
  always_comb begin
    ln_last = '0;
    unique case (state_q)
      ST_VSYNC:  ln_last = 16'(VSYNC_LINES - 1);
      ST_VBACK:  ln_last = 16'(V_BACK - 1);
      ST_ACTIVE: ln_last = 16'(V_ACTIVE - 1);
      ST_VFRONT: ln_last = 16'(V_FRONT - 1);
      default:   ln_last = '0;
    endcase
  end

  // Frame sequencer. Everything here is consumed only on ce cycles.
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    ln_d    = ln_q;
    start   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (dvp.i_enable) begin
        start   = 1'b1;
        state_d = ST_VSYNC;
        bx_d    = '0;
        ln_d    = '0;
      end
    end else if (bx_q != BX_LAST) begin
      bx_d = bx_q + BXW'(1);
    end else begin
      bx_d = '0;
      if (ln_q != ln_last) begin
        ln_d = ln_q + 16'd1;
      end else begin
        ln_d = '0;
        unique case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          ST_VFRONT: begin
            if (dvp.i_enable) begin
              state_d = ST_VSYNC;
              start   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default:   state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Bar tracking follows the pixel index of bx_d: it steps on every even byte.
  always_comb begin
    bar_d  = bar_q;
    bcnt_d = bcnt_q;
    if (bx_d == '0) begin
      bar_d  = '0;
      bcnt_d = '0;
    end else if (!bx_d[0]) begin
      if (bcnt_q == BC_LAST) begin
        bcnt_d = '0;
        bar_d  = bar_q + 3'd1;
      end else begin
        bcnt_d = bcnt_q + BCW'(1);
      end
    end
  end

  // Ramp nibble is x[7:4] = bx[8:5]; checker column bit is x[5] = bx[6].
  always_comb begin
    ramp_v = 4'(bx_d >> 5);
    chk_x  = 1'(bx_d >> 6);
    col    = 12'h000;
    unique case (pat_q)
      2'd0: begin
        unique case (bar_d)
          3'd0:    col = 12'hFFF;
          3'd1:    col = 12'hFF0;
          3'd2:    col = 12'h0FF;
          3'd3:    col = 12'h0F0;
          3'd4:    col = 12'hF0F;
          3'd5:    col = 12'hF00;
          3'd6:    col = 12'h00F;
          default: col = 12'h000;
        endcase
      end
      2'd1:    col = {ramp_v, ramp_v, ramp_v};
      2'd2:    col = (chk_x ^ ln_d[5]) ? 12'hFFF : 12'h000;
      default: col = solid_q;
    endcase
  end

  always_comb begin
    vsync_d     = (state_d == ST_VSYNC);
    href_d      = (state_d == ST_ACTIVE) && (bx_d < HREF_END);
    sof_d       = start;
    frame_cnt_d = start ? frame_cnt_q + 16'd1 : frame_cnt_q;
    pat_d       = start ? dvp.i_pattern : pat_q;
    solid_d     = start ? dvp.i_solid_color : solid_q;
    data_d      = 8'h00;
    if (href_d) data_d = bx_d[0] ? col[7:0] : {4'h0, col[11:8]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      bx_q        <= '0;
      ln_q        <= '0;
      bar_q       <= '0;
      bcnt_q      <= '0;
      pat_q       <= '0;
      solid_q     <= '0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else if (dvp.i_ce) begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      ln_q        <= ln_d;
      bar_q       <= bar_d;
      bcnt_q      <= bcnt_d;
      pat_q       <= pat_d;
      solid_q     <= solid_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      data_q      <= data_d;
      sof_q       <= sof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign dvp.o_vsync     = vsync_q;
  assign dvp.o_href      = href_q;
  assign dvp.o_data      = data_q;
  assign dvp.o_sof       = sof_q;
  assign dvp.o_busy      = (state_q != ST_IDLE);
  assign dvp.o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cam_dvp_pattern_tx.sv
// Bench for cam_dvp_pattern_tx on a reduced frame geometry, against a frame-time reference model.
module tb_cam_dvp_pattern_tx;
  localparam int H   = 64;
  localparam int VA  = 40;
  localparam int HB  = 8;
  localparam int VS  = 3;
  localparam int VB  = 2;
  localparam int VF  = 2;
  localparam int LL  = 2 * H + HB;
  localparam int FRAME = (VS + VB + VA + VF) * LL;

  logic gclk = 1'b0;
  logic rst;
  always #5 gclk = ~gclk;

  cam_dvp_pattern_tx_if dvp ();

  cam_dvp_pattern_tx #(
    .H_ACTIVE(H), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .i_clk(gclk),
    .i_rst(rst),
    .dvp  (dvp)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: position in frame as a single ce-count.
  bit          m_run;
  int          m_t;
  logic [15:0] m_fc;
  logic [1:0]  m_pat;
  logic [11:0] m_solid;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  logic [1:0]  pat;
  logic [11:0] solid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] colour(input int x, input int y);
    case (m_pat)
      2'd0:    return bars[x / (H / 8)];
      2'd1:    return {3{4'((x >> 4) & 15)}};
      2'd2:    return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: return m_solid;
    endcase
  endfunction

  function automatic logic [27:0] mexp();
    logic vs, hr, sf;
    logic [7:0] d;
    logic [11:0] c;
    int ln, b;
    vs = 0; hr = 0; sf = 0; d = 8'h00;
    if (m_run) begin
      ln = m_t / LL;
      b  = m_t % LL;
      vs = (ln < VS);
      sf = (m_t == 0);
      if (ln >= VS + VB && ln < VS + VB + VA && b < 2 * H) begin
        hr = 1;
        c  = colour(b / 2, ln - VS - VB);
        d  = (b % 2 == 0) ? {4'h0, c[11:8]} : c[7:0];
      end
    end
    return {vs, hr, d, sf, m_run, m_fc};
  endfunction

  task automatic model_edge(input bit ce, input bit en, input bit r);
    if (r) begin
      m_run = 0; m_t = 0; m_fc = 0;
    end else if (ce) begin
      if (!m_run || m_t == FRAME - 1) begin
        if (en) begin
          m_run = 1; m_t = 0; m_fc++; m_pat = pat; m_solid = solid;
        end else begin
          m_run = 0; m_t = 0;
        end
      end else begin
        m_t++;
      end
    end
  endtask

  function automatic logic [27:0] dut_vec();
    return {dvp.o_vsync, dvp.o_href, dvp.o_data, dvp.o_sof, dvp.o_busy, dvp.o_frame_cnt};
  endfunction

  task automatic tick(input bit ce, input bit en, input bit r);
    dvp.i_ce = ce; dvp.i_enable = en; rst = r;
    dvp.i_pattern = pat; dvp.i_solid_color = solid;
    @(posedge gclk);
    model_edge(ce, en, r);
    #1;
    cyc++;
    chk("out", 32'(dut_vec()), 32'(mexp()));
  endtask

  initial begin
    int t_vs[2];
    int vs_n, t_h, lidx, hrises, c_en, ones_a, ones_b;
    bit pvs, phr, en, ce, r;
    logic [7:0] lb [LL];
    bit lh [LL];

    pat = 2'd0; solid = 12'h000;
    m_run = 0; m_t = 0; m_fc = 0; m_pat = 0; m_solid = 0;
    for (int i = 0; i < 3; i++) tick(1, 0, 1);
    chk("rst_state", 32'(dut_vec()), 32'h0);

    // Bring-up frame: colour bars, ce always high.
    vs_n = 0; t_h = -1; lidx = -1; hrises = 0; pvs = 0; phr = 0;
    c_en = cyc + 1;
    for (int i = 0; i < FRAME + 5; i++) begin
      tick(1, 1, 0);
      if (i == 0) chk("fcnt_first", 32'(dvp.o_frame_cnt), 32'd1);
      if (dvp.o_vsync && !pvs) begin
        if (vs_n < 2) t_vs[vs_n] = cyc;
        vs_n++;
      end
      if (dvp.o_href && !phr) begin
        if (vs_n == 1) hrises++;
        if (t_h < 0) begin t_h = cyc; lidx = 0; end
      end
      if (lidx >= 0 && lidx < LL) begin
        lb[lidx] = dvp.o_data; lh[lidx] = dvp.o_href; lidx++;
      end
      pvs = dvp.o_vsync; phr = dvp.o_href;
    end
    chk("vs_latency", 32'(t_vs[0]), 32'(c_en));
    chk("href_delay", 32'(t_h - t_vs[0]), 32'((VS + VB) * LL));
    chk("frame_len", 32'(t_vs[1] - t_vs[0]), 32'(FRAME));
    chk("href_pulses", 32'(hrises), 32'(VA));
    ones_a = 0; ones_b = 0;
    for (int i = 0; i < LL; i++) begin
      if (i < 2 * H) ones_a += int'(lh[i]); else ones_b += int'(lh[i]);
    end
    chk("line_href_hi", 32'(ones_a), 32'(2 * H));
    chk("line_href_lo", 32'(ones_b), 32'd0);
    chk("px0", 32'({lb[0], lb[1]}), 32'h0FFF);
    chk("px_bar1", 32'({lb[2 * (H / 8)], lb[2 * (H / 8) + 1]}), 32'h0FF0);
    chk("px_last", 32'({lb[2 * H - 2], lb[2 * H - 1]}), 32'h0000);

    // Randomized segments: ce density, pattern, colour, enable and reset all vary.
    en = 1;
    for (int seg = 0; seg < 6; seg++) begin
      int ph;
      ph = 0;
      pat = 2'($urandom_range(0, 3));
      solid = 12'($urandom);
      for (int i = 0; i < 8000; i++) begin
        case (seg % 3)
          0:       ce = 1;
          1:       ce = (ph == 0);
          default: ce = 1'($urandom);
        endcase
        ph = (ph == 2) ? 0 : ph + 1;
        if ($urandom_range(0, 499) == 0) solid = 12'($urandom);
        if ($urandom_range(0, 1499) == 0) pat = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 2999) == 0) en = ~en;
        r = ($urandom_range(0, 19999) == 0);
        tick(ce, en, r);
      end
    end

    // Enable dropped mid-frame: the frame must run out and the block go idle.
    for (int k = 0; k < 2 * FRAME && !dvp.o_href; k++) tick(1, 1, 0);
    for (int k = 0; k < 4 * FRAME && dvp.o_busy; k++) tick(1, 0, 0);
    chk("idle_reach", 32'(dvp.o_busy), 32'd0);
    for (int k = 0; k < 200; k++) tick(1, 0, 0);

    // Synchronous reset in the middle of an active line.
    pat = 2'd3; solid = 12'hA5C;
    for (int k = 0; k < 2 * FRAME && !dvp.o_href; k++) tick(1, 1, 0);
    chk("in_active", 32'(dvp.o_href), 32'd1);
    tick(1, 1, 1);
    chk("rst_mid", 32'(dut_vec()), 32'h0);

    // Frame counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    m_fc = 16'hFFFF;
    tick(1, 0, 0);
    release dut.frame_cnt_q;
    tick(1, 0, 0);
    tick(1, 1, 0);
    chk("fcnt_wrap", 32'(dvp.o_frame_cnt), 32'h0);
    for (int k = 0; k < 50; k++) tick(1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
